// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy count, almost-full/almost-empty and sticky error flags.
// Define FIFO_FWFT_EN for first-word fall-through reads through a head prefetch register.
module sync_fifo_flags #(
    parameter int ASIZE    = 8,
    parameter int DSIZE    = 32,
    parameter int AF_LEVEL = 4,
    parameter int AE_LEVEL = 4
) (
    input  logic             clk,
    input  logic             in_resetn,
    input  logic [DSIZE-1:0] in_data,
    input  logic             in_wr_en,
    input  logic             in_rd_en,
    input  logic             in_clr_err,
    output logic [DSIZE-1:0] out_data,
    output logic             out_valid,
    output logic             out_full,
    output logic             out_empty,
    output logic             out_afull,
    output logic             out_aempty,
    output logic [ASIZE:0]   out_count,
    output logic             out_overflow,
    output logic             out_underflow
);
    localparam int DEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] FULL_CNT = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AF_TH    = (ASIZE+1)'(DEPTH - AF_LEVEL);
    localparam logic [ASIZE:0] AE_TH    = (ASIZE+1)'(AE_LEVEL);

    logic [DSIZE-1:0] mem [DEPTH];
    logic [ASIZE:0]   wptr, rptr, cnt_n;
    logic             wr_acc, rd_acc, ram_we, rd_ram, byp, empty_n;

    assign wr_acc = in_wr_en & ~out_full;
    assign rd_acc = in_rd_en & ~out_empty;
    assign cnt_n  = out_count + (ASIZE+1)'(wr_acc) - (ASIZE+1)'(rd_acc);

`ifdef FIFO_FWFT_EN
    logic ram_empty;
    assign ram_empty = wptr == rptr;
    // Popping the head while the RAM is empty: a concurrent write goes straight to the head.
    assign byp       = wr_acc & rd_acc & ram_empty;
    assign rd_ram    = ~ram_empty & (out_empty | rd_acc);
    assign ram_we    = wr_acc & ~byp;
    assign empty_n   = ~(rd_ram | byp | (~out_empty & ~rd_acc));
    assign out_valid = ~out_empty;
`else
    assign byp     = 1'b0;
    assign rd_ram  = rd_acc;
    assign ram_we  = wr_acc;
    assign empty_n = cnt_n == '0;
    always_ff @(posedge clk or negedge in_resetn) begin
        if (!in_resetn) out_valid <= 1'b0;
        else            out_valid <= rd_acc;
    end
`endif

    always_ff @(posedge clk) begin
        if (ram_we) mem[wptr[ASIZE-1:0]] <= in_data;
    end

    always_ff @(posedge clk or negedge in_resetn) begin
        if (!in_resetn) begin
            wptr          <= '0;
            rptr          <= '0;
            out_count     <= '0;
            out_data      <= '0;
            out_full      <= 1'b0;
            out_empty     <= 1'b1;
            out_afull     <= 1'b0;
            out_aempty    <= 1'b1;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
        end else begin
            wptr          <= wptr + (ASIZE+1)'(ram_we);
            rptr          <= rptr + (ASIZE+1)'(rd_ram);
            out_count     <= cnt_n;
            out_data      <= rd_ram ? mem[rptr[ASIZE-1:0]] : byp ? in_data : out_data;
            out_full      <= cnt_n == FULL_CNT;
            out_empty     <= empty_n;
            out_afull     <= cnt_n >= AF_TH;
            out_aempty    <= cnt_n <= AE_TH;
            out_overflow  <= (in_wr_en & out_full) | (out_overflow & ~in_clr_err);
            out_underflow <= (in_rd_en & out_empty) | (out_underflow & ~in_clr_err);
        end
    end
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed self-checking bench for sync_fifo_flags (ASIZE=8, DSIZE=32, AF/AE=4).
// Works in both the standard and the FIFO_FWFT_EN build.
module tb_sync_fifo_flags;
    localparam int ASIZE = 8;
    localparam int DSIZE = 32;

    logic             clk = 1'b0;
    logic             in_resetn, in_wr_en, in_rd_en, in_clr_err;
    logic [DSIZE-1:0] in_data, out_data;
    logic             out_valid, out_full, out_empty, out_afull, out_aempty;
    logic             out_overflow, out_underflow;
    logic [ASIZE:0]   out_count;
    int               checks = 0;
    int               failures = 0;

    sync_fifo_flags #(.ASIZE(ASIZE), .DSIZE(DSIZE), .AF_LEVEL(4), .AE_LEVEL(4)) dut (
        .clk(clk), .in_resetn(in_resetn), .in_data(in_data), .in_wr_en(in_wr_en),
        .in_rd_en(in_rd_en), .in_clr_err(in_clr_err), .out_data(out_data),
        .out_valid(out_valid), .out_full(out_full), .out_empty(out_empty),
        .out_afull(out_afull), .out_aempty(out_aempty), .out_count(out_count),
        .out_overflow(out_overflow), .out_underflow(out_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DSIZE-1:0] wd);
        in_data  = wd;
        in_wr_en = 1'b1;
        cyc();
        in_wr_en = 1'b0;
    endtask

    task automatic pop(input logic [DSIZE-1:0] exp);
`ifdef FIFO_FWFT_EN
        check("head_valid", out_valid, 1);
        check("head_data", out_data, exp);
        in_rd_en = 1'b1;
        cyc();
        in_rd_en = 1'b0;
`else
        in_rd_en = 1'b1;
        cyc();
        in_rd_en = 1'b0;
        check("rd_valid", out_valid, 1);
        check("rd_data", out_data, exp);
`endif
    endtask

    task automatic xfer(input logic [DSIZE-1:0] wd, input logic [DSIZE-1:0] exp);
        in_data  = wd;
        in_wr_en = 1'b1;
        pop(exp);
        in_wr_en = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, out_count, 0);
        check({tag, "_empty"}, out_empty, 1);
        check({tag, "_aempty"}, out_aempty, 1);
        check({tag, "_full"}, out_full, 0);
        check({tag, "_afull"}, out_afull, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_ovf"}, out_overflow, 0);
        check({tag, "_unf"}, out_underflow, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_resetn  = 1'b0;
        in_wr_en   = 1'b0;
        in_rd_en   = 1'b0;
        in_clr_err = 1'b0;
        in_data    = '0;
        cyc();
        cyc();
        check_reset_state("reset");
        in_resetn = 1'b1;
        cyc();

        // single write then single read
        push(32'hA5A5_0001);
        check("t1_count_w", out_count, 1);
`ifndef FIFO_FWFT_EN
        check("t1_empty_w", out_empty, 0);
`endif
        cyc();
        check("t1_empty_settled", out_empty, 0);
        pop(32'hA5A5_0001);
        check("t1_count_r", out_count, 0);
        check("t1_empty_r", out_empty, 1);
        cyc();
        check("t1_valid_drop", out_valid, 0);

        // underflow, error-wins-over-clear, then clear
        in_rd_en = 1'b1;
        cyc();
        check("t3_unf", out_underflow, 1);
        check("t3_count", out_count, 0);
        check("t3_data_hold", out_data, 32'hA5A5_0001);
        in_clr_err = 1'b1;
        cyc();
        check("t3_err_wins", out_underflow, 1);
        in_rd_en = 1'b0;
        cyc();
        in_clr_err = 1'b0;
        check("t3_clr", out_underflow, 0);

        // fill to full, overflow, drain in order
        for (int i = 0; i < 256; i++) begin
            push(DSIZE'(i));
            if (i == 250) check("t2_afull_251", out_afull, 0);
            if (i == 251) check("t2_afull_252", out_afull, 1);
            if (i == 254) check("t2_full_255", out_full, 0);
        end
        check("t2_full", out_full, 1);
        check("t2_count_full", out_count, 256);
        push(32'hDEAD_BEEF);
        check("t2_ovf", out_overflow, 1);
        check("t2_count_ovf", out_count, 256);
        in_clr_err = 1'b1;
        cyc();
        in_clr_err = 1'b0;
        check("t2_ovf_clr", out_overflow, 0);
        for (int j = 0; j < 256; j++) begin
            pop(DSIZE'(j));
            if (j == 0) check("t2_full_drop", out_full, 0);
            if (j == 250) check("t2_aempty_5", out_aempty, 0);
            if (j == 251) check("t2_aempty_4", out_aempty, 1);
        end
        check("t2_empty", out_empty, 1);
        check("t2_unf_none", out_underflow, 0);

        // simultaneous write+read at count 1 and count 255
        push(100);
        cyc();
        for (int k = 0; k < 10; k++) begin
            xfer(DSIZE'(101 + k), DSIZE'(100 + k));
            check("t4_count1", out_count, 1);
        end
        for (int k = 0; k < 254; k++) push(DSIZE'(111 + k));
        check("t4_count255", out_count, 255);
        check("t4_afull255", out_afull, 1);
        for (int k = 0; k < 10; k++) begin
            xfer(DSIZE'(365 + k), DSIZE'(110 + k));
            check("t4_count255_x", out_count, 255);
            check("t4_nofull", out_full, 0);
        end
        for (int k = 0; k < 255; k++) pop(DSIZE'(120 + k));
        check("t4_drained", out_count, 0);

        // continuous streaming across several pointer wraps
        for (int k = 0; k < 3; k++) push(DSIZE'(1000 + k));
        cyc();
        check("t5_aempty3", out_aempty, 1);
        for (int k = 0; k < 800; k++) begin
            xfer(DSIZE'(1003 + k), DSIZE'(1000 + k));
            check("t5_count", out_count, 3);
            check("t5_aempty", out_aempty, 1);
        end
        push(1803);
        check("t5_aempty4", out_aempty, 1);
        push(1804);
        check("t5_aempty5", out_aempty, 0);
        cyc();
        for (int k = 0; k < 5; k++) pop(DSIZE'(1800 + k));
        check("t5_empty", out_empty, 1);

        // asynchronous reset mid-operation
        for (int k = 0; k < 100; k++) push(DSIZE'(5000 + k));
        check("t6_count100", out_count, 100);
        #1 in_resetn = 1'b0;
        #1 check_reset_state("t6_async");
        cyc();
        in_resetn = 1'b1;
        cyc();
        push(32'h0000_600D);
        cyc();
        pop(32'h0000_600D);
        cyc();
        check("t6_count_end", out_count, 0);
        check("t6_valid_end", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
